systolic_feed_ctrl: RTL
=======================

SYSTOLIC_FEED_CTRL -- requirements
Module: systolic_feed_ctrl

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter N, default 3, array dimension (N x N PEs), N >= 2.
REQ-003 SHALL have parameter PE_LAT, default 1, cycles from a PE's operand arrival to its accumulator update.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rstn  input  1  reset, asynchronous assert, active-low.
REQ-006 start  input  1  request a new job; sampled only in IDLE.
REQ-007 abort  input  1  synchronous job cancel.
REQ-008 ld_valid  input  1  load beat valid.
REQ-009 ld_ready  output  1  load beat accepted when ld_valid && ld_ready.
REQ-010 ld_data  input  N x DWIDTH (unpacked [N])  one A row or one B column per beat.
REQ-011 north  output  N x DWIDTH (unpacked [N])  to the array's north inputs.
REQ-012 west  output  N x DWIDTH (unpacked [N])  to the array's west inputs.
REQ-013 arr_clr  output  1  one-cycle accumulator-clear pulse to the array.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse; array results valid.

Function
REQ-016 SHALL implement states IDLE, LOAD, CLEAR, FEED, DRAIN, DONE.
REQ-017 IDLE: start=1 -> LOAD next cycle; start in any other state SHALL be ignored.
REQ-018 LOAD: ld_ready=1; 2N beats accepted in order: beats 0..N-1 = A rows 0..N-1, beats N..2N-1 = B columns 0..N-1; ld_valid=0 cycles stall without losing count.
REQ-019 After beat 2N-1 is accepted: -> CLEAR; ld_ready SHALL be 0 in every state except LOAD.
REQ-020 CLEAR: exactly 1 cycle, arr_clr=1, -> FEED.
REQ-021 FEED: exactly 2N-1 cycles, feed step t = 0..2N-2.
REQ-022 At step t: west[r] = A[r][t-r] and north[c] = B[t-c][c] when 0 <= t-r < N (resp. t-c); otherwise 0.
REQ-023 north/west SHALL be 0 in every state other than FEED; never X.
REQ-024 FEED -> DRAIN; DRAIN lasts exactly N-1+PE_LAT cycles, covering the hops to PE(N-1,N-1) plus its update.
REQ-025 DRAIN -> DONE; DONE lasts 1 cycle with done=1, -> IDLE.
REQ-026 Job latency, first CLEAR cycle to done: 1 + (2N-1) + (N-1+PE_LAT) cycles (N=3, PE_LAT=1: 9 cycles).
REQ-027 abort=1 in any non-IDLE state: -> IDLE next cycle, arr_clr=1 that cycle, no done, load counter cleared; abort in IDLE SHALL be ignored.
REQ-028 abort and start asserted together in IDLE: start is taken.
REQ-029 abort and the final LOAD beat in the same cycle: abort wins, beat discarded.
REQ-030 Operand buffers SHALL hold their contents after DONE; a new job overwrites all 2N entries.
REQ-031 Counters SHALL be ceil(log2) sized for 2N beats and 2N-1 steps, with no wrap inside a state.

Reset
REQ-032 While rstn=0: state=IDLE, ld_ready=0, busy=0, done=0, arr_clr=0, north/west all 0, counters 0; operand buffers need not be reset.
REQ-033 Reset asserted mid-job SHALL drop the job with no done pulse; the first start after release SHALL begin a fresh LOAD.

Verification
REQ-034 N=3, load A rows {1,2,3},{4,5,6},{7,8,9}, B cols {10,13,16},{11,14,17},{12,15,18}, array attached -> FEED step 1 shows west={2,4,0}, north={13,11,0}; done 9 cycles after CLEAR; results = 84,90,96,201,216,231,318,342,366.
REQ-035 Same job with ld_valid low on alternate cycles -> identical north/west sequence and results; ld_ready high throughout LOAD.
REQ-036 start pulsed during FEED -> ignored; exactly one done; next start in IDLE runs a second job whose results equal the first (arr_clr cleared old sums).
REQ-037 abort at FEED step 2 -> IDLE next cycle, arr_clr=1 for 1 cycle, done never pulses, north/west=0.
REQ-038 rstn low for 1 cycle during DRAIN -> all outputs at reset values immediately; no done; a subsequent full job gives correct results.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// Systolic-array feeder: buffers N A-rows and N B-columns, then skews them onto west/north over 2N-1 steps.
// Latency CLEAR->done = 1 + (2N-1) + (N-1+PE_LAT); ld_ready only in LOAD, so ld_valid stalls without losing count.
module systolic_feed_ctrl #(
  parameter int DWIDTH = 32,
  parameter int N      = 3,
  parameter int PE_LAT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DWIDTH-1:0] ld_data [N],
  output logic [DWIDTH-1:0] north   [N],
  output logic [DWIDTH-1:0] west    [N],
  output logic              arr_clr,
  output logic              busy,
  output logic              done
);
  localparam int BEATS     = 2 * N;
  localparam int FEED_LEN  = 2 * N - 1;
  localparam int DRAIN_LEN = N - 1 + PE_LAT;
  localparam int LW        = $clog2(BEATS);
  localparam int SW        = $clog2(FEED_LEN);
  localparam int DRW       = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;
  localparam int IW        = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CLEAR, S_FEED, S_DRAIN, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [LW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [SW-1:0]     step_q, step_d;
  logic [DRW-1:0]    drn_q, drn_d;

  // a_q[r][k] = A[r][k]; b_q[c][k] = B[k][c] (stored column-wise as loaded)
  logic [DWIDTH-1:0] a_q [N][N];
  logic [DWIDTH-1:0] a_d [N][N];
  logic [DWIDTH-1:0] b_q [N][N];
  logic [DWIDTH-1:0] b_d [N][N];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      step_q   <= '0;
      drn_q    <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      step_q   <= step_d;
      drn_q    <= drn_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    step_d   = step_q;
    drn_d    = drn_q;
    if (state_q != S_IDLE && abort) begin
      state_d  = S_IDLE;
      ld_cnt_d = '0;
      step_d   = '0;
      drn_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_LOAD;
            ld_cnt_d = '0;
          end
        end
        S_LOAD: begin
          if (ld_valid) begin
            if (ld_cnt_q == LW'(BEATS - 1)) begin
              state_d  = S_CLEAR;
              ld_cnt_d = '0;
            end else begin
              ld_cnt_d = ld_cnt_q + LW'(1);
            end
          end
        end
        S_CLEAR: begin
          state_d = S_FEED;
          step_d  = '0;
        end
        S_FEED: begin
          if (step_q == SW'(FEED_LEN - 1)) begin
            state_d = S_DRAIN;
            step_d  = '0;
            drn_d   = '0;
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        S_DRAIN: begin
          if (drn_q == DRW'(DRAIN_LEN - 1)) begin
            state_d = S_DONE;
            drn_d   = '0;
          end else begin
            drn_d = drn_q + DRW'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // An aborted beat, including the final one, must not touch the buffers.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (state_q == S_LOAD && ld_valid && !abort) begin
      for (int i = 0; i < N; i++) begin
        if (ld_cnt_q == LW'(i))     a_d[i] = ld_data;
        if (ld_cnt_q == LW'(N + i)) b_d[i] = ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  always_comb begin
    int k;
    k        = 0;
    ld_ready = (state_q == S_LOAD);
    busy     = (state_q != S_IDLE);
    arr_clr  = (state_q == S_CLEAR) || ((state_q != S_IDLE) && abort);
    done     = (state_q == S_DONE) && !abort;
    for (int i = 0; i < N; i++) begin
      north[i] = '0;
      west[i]  = '0;
      k        = int'(step_q) - i;
      if (state_q == S_FEED && k >= 0 && k < N) begin
        west[i]  = a_q[i][IW'(k)];
        north[i] = b_q[i][IW'(k)];
      end
    end
  end

endmodule
